// File: rtl/bcd_time_entry_pkg.sv
// Shared constants and helpers for the countdown-timer entry front end.
// State encodings, BCD limits and the per-cycle button pulse bundle.
package bcd_time_entry_pkg;

  localparam logic [1:0] ST_EDIT = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] SEL_RESET = 4'b0001;

  // Field order matches action priority, highest first.
  typedef struct packed {
    logic start;
    logic next;
    logic up;
    logic down;
  } btn_pulse_t;

  // One BCD digit stepped up or down with wrap and no carry.
  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
    if (up)
      return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    else
      return (d == 4'd0) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_time_entry_btn_debounce.sv
// One push-button input chain: 2-flop synchroniser, CE-paced debounce counter
// and a registered one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEB_SAMPLES = 20,
  parameter int DEB_BITS    = 5
) (
  input  logic CLK,
  input  logic CLR,
  input  logic CE,
  input  logic BTN,
  output logic PRESS
);

  localparam logic [DEB_BITS-1:0] CNT_LAST = DEB_BITS'(DEB_SAMPLES - 1);

  logic                sync1_reg;
  logic                sync2_reg;
  logic                stable_reg;
  logic                press_reg;
  logic [DEB_BITS-1:0] cnt_reg;
  logic                accept;

  // The level is taken on the last of DEB_SAMPLES consecutive differing samples.
  assign accept = CE && (sync2_reg != stable_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= BTN;
      sync2_reg <= sync1_reg;
      press_reg <= accept && sync2_reg;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (CE) begin
        if (cnt_reg == CNT_LAST) begin
          stable_reg <= sync2_reg;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign PRESS = press_reg;

endmodule

// File: rtl/bcd_time_entry.sv
// Countdown-timer entry front end: four debounced buttons edit a 4-digit BCD
// preset, then a one-cycle LOAD strobe and a RUN level drive the countdown.
module bcd_time_entry
  import bcd_time_entry_pkg::*;
#(
  parameter int          DEB_SAMPLES = 20,
  parameter int          DEB_BITS    = 5,
  parameter logic [15:0] INIT_VALUE  = 16'h0000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        CE,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  input  logic        BTN_NEXT,
  input  logic        BTN_START,
  input  logic        DONE,
  output logic [15:0] DIGITS,
  output logic [3:0]  SEL,
  output logic        EDIT,
  output logic        LOAD,
  output logic        RUN
);

  logic [3:0]  btn_raw;
  logic [3:0]  press;
  btn_pulse_t  pulse;

  logic [1:0]  state_reg, state_next;
  logic [15:0] digits_reg, digits_next;
  logic [3:0]  sel_reg, sel_next;
  logic        edit_reg, load_reg, run_reg;

  logic [15:0] digit_inc;
  logic [15:0] digit_dec;
  logic [15:0] sel_mask;

  assign btn_raw = {BTN_START, BTN_NEXT, BTN_UP, BTN_DOWN};
  assign pulse   = press;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
        .DEB_SAMPLES(DEB_SAMPLES),
        .DEB_BITS   (DEB_BITS)
      ) u_deb (
        .CLK  (CLK),
        .CLR  (CLR),
        .CE   (CE),
        .BTN  (btn_raw[gi]),
        .PRESS(press[gi])
      );
    end

    // Per-nibble stepped values; the select mask picks the one digit that changes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_inc[gi*4 +: 4] = bcd_step(digits_reg[gi*4 +: 4], 1'b1);
      assign digit_dec[gi*4 +: 4] = bcd_step(digits_reg[gi*4 +: 4], 1'b0);
      assign sel_mask[gi*4 +: 4]  = {4{sel_reg[gi]}};
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    digits_next = digits_reg;
    sel_next    = sel_reg;
    case (state_reg)
      ST_EDIT: begin
        if (pulse.start) begin
          if (digits_reg != '0)
            state_next = ST_LOAD;
        end else if (pulse.next) begin
          sel_next = {sel_reg[2:0], sel_reg[3]};
        end else if (pulse.up) begin
          digits_next = (digits_reg & ~sel_mask) | (digit_inc & sel_mask);
        end else if (pulse.down) begin
          digits_next = (digits_reg & ~sel_mask) | (digit_dec & sel_mask);
        end
      end
      ST_LOAD: state_next = ST_RUN;
      ST_RUN: begin
        if (pulse.start || DONE)
          state_next = ST_EDIT;
      end
      default: state_next = ST_EDIT;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_reg  <= ST_EDIT;
      digits_reg <= INIT_VALUE;
      sel_reg    <= SEL_RESET;
      edit_reg   <= 1'b1;
      load_reg   <= 1'b0;
      run_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      digits_reg <= digits_next;
      sel_reg    <= sel_next;
      edit_reg   <= (state_next == ST_EDIT);
      load_reg   <= (state_next == ST_LOAD);
      run_reg    <= (state_next == ST_RUN);
    end
  end

  assign DIGITS = digits_reg;
  assign SEL    = sel_reg;
  assign EDIT   = edit_reg;
  assign LOAD   = load_reg;
  assign RUN    = run_reg;

endmodule

// File: doc/bcd_time_entry.md
Name: bcd_time_entry

Overview:
User-input front end for the countdown timer. It debounces four push-buttons and lets the user edit a 4-digit BCD start value. It issues a one-cycle LOAD strobe plus a RUN level to the countdown datapath. It is the input-side counterpart of the 7-segment display path: DIGITS and SEL feed the display mux, which shows and blinks the digit being edited.

Parameters:
DEB_SAMPLES, 20, consecutive CE ticks a button level must hold before it is accepted (range 2..31)
DEB_BITS, 5, width of each debounce counter; must hold DEB_SAMPLES-1
INIT_VALUE, 16'h0000, reset value of DIGITS; every nibble must be 0..9

Ports:
CLK  in  1  system clock
CLR  in  1  reset, asynchronous, active-high
CE  in  1  debounce sample tick, one CLK cycle wide (about 1 kHz from a prescaler)
BTN_UP  in  1  raw button, asynchronous, active-high
BTN_DOWN  in  1  raw button, asynchronous, active-high
BTN_NEXT  in  1  raw button, asynchronous, active-high
BTN_START  in  1  raw button, asynchronous, active-high
DONE  in  1  countdown reached zero; one-cycle pulse
DIGITS  out  16  BCD value; [3:0] = units, [15:12] = thousands
SEL  out  4  one-hot selected digit; bit0 = units
EDIT  out  1  high in EDIT state
LOAD  out  1  one-cycle strobe; countdown loads DIGITS on this cycle
RUN  out  1  high in RUN state

Behaviour:
- Reset (CLR high, asynchronous) forces:
  - DIGITS=INIT_VALUE, SEL=4'b0001
  - state EDIT, so EDIT=1, LOAD=0, RUN=0
  - all synchronisers, debounce stables and counters to 0
- Per-button input chain:
  - 2-flop synchroniser on CLK gives the synced level.
  - Counter clears on any cycle where synced == stable.
  - On a CE cycle with synced != stable, the counter increments.
  - When the counter equals DEB_SAMPLES-1 on such a cycle, stable <= synced and the counter clears.
  - Effect: a new level is accepted only after DEB_SAMPLES consecutive differing CE samples. A glitch shorter than that is dropped.
  - Press pulse = stable rising edge, exactly one CLK wide, registered. Release produces no pulse.
- Action priority per cycle: START > NEXT > UP > DOWN. Only the highest-priority pending pulse acts; the lower pulses that cycle are discarded.
- FSM states: EDIT, LOAD, RUN. State is registered; all outputs are registered decodes of state, with no combinational path from inputs to outputs.
- EDIT state:
  - UP: selected digit +1, 9 wraps to 0. Other digits unchanged; no carry.
  - DOWN: selected digit -1, 0 wraps to 9; no borrow.
  - NEXT: SEL rotates left, 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - START with DIGITS != 0: go to LOAD.
  - START with DIGITS == 0: ignored, stay in EDIT.
  - DONE: ignored.
- LOAD state: LOAD=1 for exactly one cycle, then go to RUN unconditionally. All button pulses that cycle are discarded.
- RUN state:
  - UP, DOWN and NEXT are ignored; DIGITS and SEL stay frozen.
  - START (abort) or DONE: go to EDIT. If both arrive the same cycle, go to EDIT once.
  - DIGITS keeps the last entered value, so re-start uses the same preset.
- Latency from a button edge to its pulse: 2 CLK (synchroniser), then DEB_SAMPLES CE ticks, then 1 CLK. A state or digit update appears 1 CLK after the pulse.
- CE held low: debounce freezes; no new presses.
- Button held: one action only; no auto-repeat.
- Reset mid-RUN or mid-LOAD: immediate return to reset values; a LOAD strobe is truncated.

Decomposition:
- Shared header (`include) holds:
  - state encodings ST_EDIT=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2
  - BCD_MAX=4'd9
  - SEL_RESET=4'b0001
- Sub-module btn_debounce: synchroniser, debounce counter and rising-edge pulse, parameterised by DEB_SAMPLES and DEB_BITS. Instantiated 4 times.
- The top level holds the FSM and the digit/selection datapath.

Test Plan:
- Reset with INIT_VALUE=16'h1234 and DEB_SAMPLES=4 -> DIGITS=1234, SEL=0001, EDIT=1, LOAD=0, RUN=0. Releasing CLR mid-cycle causes no glitch.
- BTN_UP bounce of 3 CE ticks high then low -> no pulse and DIGITS unchanged. Held for 4 CE ticks -> units 4 -> 5 exactly once while held.
- From 0000: NEXT x3 gives SEL=1000. DOWN gives DIGITS=9000. UP x2 gives 1000 (9 -> 0 -> 1, no carry). NEXT gives SEL=0001.
- DIGITS=0000, press START -> stays EDIT, LOAD never asserts. Then UP, then START -> LOAD high for exactly 1 CLK with DIGITS=0001, then RUN=1.
- In RUN: UP/NEXT have no effect. A DONE pulse gives EDIT=1 next cycle with DIGITS=0001. Re-enter RUN; START aborts to EDIT.
- Same cycle in EDIT, NEXT and UP pulses coincide -> only SEL rotates, digit unchanged. Assert CLR during LOAD -> LOAD drops immediately and all outputs take reset values.
